// File: rtl/demux_pkg.sv
// Shared defaults and output-state encoding for the 1-to-16 serial demultiplexer.
package demux_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned IDX_W_DEFAULT = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sel_counter.sv
// Demux select counter: wraps modulo WIDTH; clear beats inc, clear+inc lands on 1.
module sel_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [IDX_W-1:0] count,
  output logic             wrap_c
);

  assign wrap_c = inc && (count == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? IDX_W'(1) : '0;
    end else if (inc) begin
      count <= count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/demux_1x16_deser.sv
// Rebuilds parallel words from an LSB-first serial stream and offers them on a
// valid/ready port, flagging words that overwrite an unconsumed one.
module demux_1x16_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             align,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] sel,
  output logic             overrun,
  input  logic             clr_ovr
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] merged_c;
  logic             ovr_d;
  logic             wrap_c;
  logic             complete_c;

  sel_counter #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_sel (
    .clk    (clk),
    .rst    (rst),
    .inc    (in_valid),
    .clear  (align),
    .count  (sel),
    .wrap_c (wrap_c)
  );

  // An align edge restarts the word, so it can never also finish one.
  assign complete_c = wrap_c && !align;
  assign merged_c   = asm_q | (WIDTH'(in_bit) << sel);
  assign out_valid  = (state_q == FULL);

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    word_d  = out_word;
    ovr_d   = overrun;

    if (align) begin
      asm_d = in_valid ? WIDTH'(in_bit) : '0;
    end else if (in_valid) begin
      asm_d = complete_c ? '0 : merged_c;
    end

    if (complete_c) begin
      word_d = merged_c;
    end

    if (clr_ovr) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      EMPTY: begin
        if (complete_c) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete_c && !out_ready) begin
          ovr_d = 1'b1;
        end else if (!complete_c && out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      asm_q    <= '0;
      out_word <= '0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      asm_q    <= asm_d;
      out_word <= word_d;
      overrun  <= ovr_d;
    end
  end

endmodule

// File: tb/tb_demux_1x16_deser.sv
// Self-checking bench for demux_1x16_deser: vector table, directed corner cases
// and random traffic compared every cycle against a queue-based reference model.
module tb_demux_1x16_deser;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_bit;
  logic             in_valid;
  logic             align;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] sel;
  logic             overrun;
  logic             clr_ovr;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit               m_bits[$];
  logic [WIDTH-1:0] m_word;
  logic             m_valid;
  logic             m_ovr;

  typedef struct {
    logic       iv;
    logic       ib;
    logic       al;
    logic       rdy;
    logic       clr;
    logic [3:0] exp_sel;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[8];

  demux_1x16_deser dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .align     (align),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, from the inputs present at the edge.
  task automatic model_edge();
    logic             done;
    logic [WIDTH-1:0] w;
    done = 1'b0;
    w    = '0;
    if (rst) begin
      m_bits.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (align) begin
        m_bits.delete();
        if (in_valid) m_bits.push_back(in_bit);
      end else if (in_valid) begin
        m_bits.push_back(in_bit);
        if (m_bits.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) w = w | (WIDTH'(m_bits[i]) << i);
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (clr_ovr) m_ovr = 1'b0;
      if (done) begin
        if (m_valid && !out_ready) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_word  = w;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    chk("model_sel", 32'(sel), 32'(m_bits.size()));
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_ovr", 32'(overrun), 32'(m_ovr));
    if (m_valid) chk("model_word", 32'(out_word), 32'(m_word));
  endtask

  task automatic step(input logic iv, input logic ib, input logic al,
                      input logic rdy, input logic cl);
    in_valid  = iv;
    in_bit    = ib;
    align     = al;
    out_ready = rdy;
    clr_ovr   = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    align     = 1'b0;
    out_ready = 1'b0;
    clr_ovr   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    rst = 1'b0;
    chk("rst_word", 32'(out_word), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
  endtask

  // Sends bits [first..last] of w; rdy_last applies to the final bit only.
  task automatic send_bits(input logic [WIDTH-1:0] w, input int first, input int last,
                           input logic rdy, input logic rdy_last, input int gap_pct);
    for (int i = first; i <= last; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) step(1'b0, 1'b1, 1'b0, rdy, 1'b0);
      step(1'b1, w[i], 1'b0, (i == last) ? rdy_last : rdy, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

    do_reset();

    for (int v = 0; v < 8; v++) begin
      step(vecs[v].iv, vecs[v].ib, vecs[v].al, vecs[v].rdy, vecs[v].clr);
      chk($sformatf("vec%0d_sel", v), 32'(sel), 32'(vecs[v].exp_sel));
      chk($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
    end

    // First word after reset, consumer always ready: one-cycle valid pulse.
    send_bits(16'haaaa, 0, 15, 1'b1, 1'b1, 0);
    chk("aaaa_valid", 32'(out_valid), 32'h1);
    chk("aaaa_word", 32'(out_word), 32'haaaa);
    chk("aaaa_sel", 32'(sel), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("aaaa_pulse_end", 32'(out_valid), 32'h0);

    // Gapped input: sel only moves on accepted bits.
    begin
      logic [WIDTH-1:0] w;
      w = 16'h5a3c;
      for (int i = 0; i < WIDTH; i++) begin
        while ($urandom_range(99) < 40) begin
          step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
          chk("gap_idle_sel", 32'(sel), 32'(i));
        end
        step(1'b1, w[i], 1'b0, 1'b1, 1'b0);
        chk("gap_sel", 32'((i + 1) % WIDTH), 32'(sel));
      end
      chk("gap_word", 32'(out_word), 32'h5a3c);
      chk("gap_valid", 32'(out_valid), 32'h1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back words with a stalled consumer.
    send_bits(16'haaaa, 0, 15, 1'b0, 1'b0, 0);
    chk("b2b_first_ovr", 32'(overrun), 32'h0);
    send_bits(16'h5555, 0, 15, 1'b0, 1'b0, 0);
    chk("b2b_word", 32'(out_word), 32'h5555);
    chk("b2b_ovr", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_hs_valid", 32'(out_valid), 32'h0);
    chk("b2b_ovr_sticky", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_ovr_clr", 32'(overrun), 32'h0);

    // Consume and complete on the same edge.
    send_bits(16'h1234, 0, 15, 1'b0, 1'b0, 0);
    send_bits(16'h0f0f, 0, 15, 1'b0, 1'b1, 0);
    chk("cc_valid", 32'(out_valid), 32'h1);
    chk("cc_word", 32'(out_word), 32'h0f0f);
    chk("cc_ovr", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Align after 7 bits, new word restarts with the align-edge bit.
    send_bits(16'hffff, 0, 6, 1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("al_sel", 32'(sel), 32'h1);
    chk("al_no_word", 32'(out_valid), 32'h0);
    send_bits(16'h8001, 1, 15, 1'b0, 1'b0, 0);
    chk("al_word", 32'(out_word), 32'h8001);
    chk("al_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Align alone at sel=15, then align with a bit at sel=15: never completes.
    send_bits(16'hffff, 0, 14, 1'b1, 1'b1, 0);
    chk("al15_pre_sel", 32'(sel), 32'hf);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("al15_sel", 32'(sel), 32'h0);
    chk("al15_valid", 32'(out_valid), 32'h0);
    send_bits(16'hffff, 0, 14, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("al15v_sel", 32'(sel), 32'h1);
    chk("al15v_valid", 32'(out_valid), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-word with a word pending.
    send_bits(16'hbeef, 0, 15, 1'b0, 1'b0, 0);
    send_bits(16'hffff, 0, 8, 1'b0, 1'b0, 0);
    chk("mr_pre_sel", 32'(sel), 32'h9);
    chk("mr_pre_valid", 32'(out_valid), 32'h1);
    do_reset();
    send_bits(16'hc3a5, 0, 15, 1'b0, 1'b0, 0);
    chk("mr_word", 32'(out_word), 32'hc3a5);
    chk("mr_valid", 32'(out_valid), 32'h1);

    // Random traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      step(1'($urandom_range(99) < 75), 1'($urandom_range(1)),
           1'($urandom_range(99) < 4), 1'($urandom_range(99) < 50),
           1'($urandom_range(99) < 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
